// File: rtl/div_const_recon_if.sv
// Handshake bundle for div_const_recon: quotient/remainder in, reconstructed dividend out.
interface div_const_recon_if #(
  parameter int X_WIDTH = 16,
  parameter int Q_WIDTH = 14,
  parameter int R_WIDTH = 3
);
  logic [Q_WIDTH-1:0] in_q;
  logic [R_WIDTH-1:0] in_r;
  logic               in_valid;
  logic               in_ready;
  logic [X_WIDTH-1:0] out_x;
  logic               out_r_err;
  logic               out_ovf;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_q, in_r, in_valid, out_ready,
    input  in_ready, out_x, out_r_err, out_ovf, out_valid
  );

  modport slave (
    input  in_q, in_r, in_valid, out_ready,
    output in_ready, out_x, out_r_err, out_ovf, out_valid
  );
endinterface

// File: rtl/div_const_recon.sv
// Rebuilds X = DIVISOR*Q + R by sequential shift-add, one DIVISOR bit per BUSY cycle.
// Single transaction in flight; all outputs are registered.
module div_const_recon #(
  parameter int X_WIDTH = 16,
  parameter int Q_WIDTH = 14,
  parameter int R_WIDTH = 3,
  parameter int DIVISOR = 5,
  parameter int D_BITS  = 3
) (
  input  logic clk,
  input  logic rst,
  div_const_recon_if.slave bus
);

  localparam int AW = Q_WIDTH + D_BITS + 1;
  localparam int CW = (D_BITS > 1) ? $clog2(D_BITS) : 1;
  localparam logic [D_BITS-1:0] DIV_BITS = D_BITS'(DIVISOR);
  localparam logic [31:0]       DIV32    = 32'(DIVISOR);
  localparam logic [CW-1:0]     CNT_LAST = CW'(D_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [AW-1:0]      acc_r;
  logic [Q_WIDTH-1:0] q_r;
  logic [CW-1:0]      cnt_r;
  logic               r_err_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [X_WIDTH-1:0] out_x_r;
  logic               out_ovf_r;
  logic               out_r_err_r;

  logic [AW-1:0]      pp_s;
  logic [AW-1:0]      sum_s;

  // Partial product for the current DIVISOR bit; zero bits still take a cycle.
  always_comb begin
    pp_s  = AW'(q_r) << cnt_r;
    sum_s = acc_r;
    if (DIV_BITS[cnt_r]) begin
      sum_s = acc_r + pp_s;
    end else begin
      sum_s = acc_r;
    end
  end

  // Control FSM with datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {AW{1'b0}};
      q_r         <= {Q_WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      r_err_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_x_r     <= {X_WIDTH{1'b0}};
      out_ovf_r   <= 1'b0;
      out_r_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            acc_r      <= AW'(bus.in_r);
            q_r        <= bus.in_q;
            r_err_r    <= (32'(bus.in_r) >= DIV32);
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + CW'(1);
          // Final bit: publish the result directly from the sum so DONE entry has it.
          if (cnt_r == CNT_LAST) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            out_x_r     <= sum_s[X_WIDTH-1:0];
            out_ovf_r   <= |sum_s[AW-1:X_WIDTH];
            out_r_err_r <= r_err_r;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_x     = out_x_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_r_err = out_r_err_r;

endmodule

// File: tb/tb_div_const_recon.sv
// Directed self-checking bench for div_const_recon (defaults: DIVISOR=5, 16/14/3 widths).
module tb_div_const_recon;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  div_const_recon_if #(.X_WIDTH(16), .Q_WIDTH(14), .R_WIDTH(3)) bus ();

  div_const_recon #(
    .X_WIDTH(16), .Q_WIDTH(14), .R_WIDTH(3), .DIVISOR(5), .D_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair, wait for acceptance and result, then consume it.
  task automatic drive_pair(input logic [13:0] q, input logic [2:0] r,
                            output int lat, output logic [15:0] x,
                            output logic ovf, output logic err);
    int w;
    bus.in_q = q;
    bus.in_r = r;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      step();
      w++;
    end
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    x   = bus.out_x;
    ovf = bus.out_ovf;
    err = bus.out_r_err;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.out_x !== 16'd0) begin n_errors++; $display("FAIL reset_out_x: got %0d expected 0", bus.out_x); end
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_out_ovf: got %b expected 0", bus.out_ovf); end
    n_checks++; if (bus.out_r_err !== 1'b0) begin n_errors++; $display("FAIL reset_out_r_err: got %b expected 0", bus.out_r_err); end
  endtask

  task automatic test_latency();
    int lat;
    bus.in_q = 14'd13107;
    bus.in_r = 3'd0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL lat_in_ready_drop: got %b expected 0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL lat_edges: got %0d expected 3", lat); end
    n_checks++; if (bus.out_x !== 16'd65535) begin n_errors++; $display("FAIL lat_out_x: got %0d expected 65535", bus.out_x); end
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_errors++; $display("FAIL lat_ovf: got %b expected 0", bus.out_ovf); end
    n_checks++; if (bus.out_r_err !== 1'b0) begin n_errors++; $display("FAIL lat_r_err: got %b expected 0", bus.out_r_err); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL lat_valid_clear: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL lat_ready_back: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_flags();
    int lat;
    logic [15:0] x;
    logic ovf, err;
    drive_pair(14'd13107, 3'd1, lat, x, ovf, err);
    n_checks++; if (x !== 16'd0) begin n_errors++; $display("FAIL ovf_x: got %0d expected 0", x); end
    n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ovf_r_err: got %b expected 0", err); end
    drive_pair(14'd2, 3'd5, lat, x, ovf, err);
    n_checks++; if (x !== 16'd15) begin n_errors++; $display("FAIL rerr_x: got %0d expected 15", x); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL rerr_flag: got %b expected 1", err); end
    n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL rerr_ovf: got %b expected 0", ovf); end
    drive_pair(14'd0, 3'd4, lat, x, ovf, err);
    n_checks++; if (x !== 16'd4) begin n_errors++; $display("FAIL zero_q_x: got %0d expected 4", x); end
    n_checks++; if (ovf !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL zero_q_flags: got ovf=%b err=%b expected 0 0", ovf, err); end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.in_q = 14'd100;
    bus.in_r = 3'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    n_checks++; if (bus.out_x !== 16'd503) begin n_errors++; $display("FAIL bp_x: got %0d expected 503", bus.out_x); end
    bus.in_q = 14'd1;
    bus.in_r = 3'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (bus.out_x !== 16'd503 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got x=%0d valid=%b ready=%b expected 503 1 0", i, bus.out_x, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_accept: got in_ready=%b expected 0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    n_checks++; if (bus.out_x !== 16'd6 || lat !== 3) begin n_errors++; $display("FAIL bp_next: got x=%0d lat=%0d expected 6 3", bus.out_x, lat); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midbusy();
    int lat;
    logic [15:0] x;
    logic ovf, err;
    logic seen;
    bus.in_q = 14'd500;
    bus.in_r = 3'd2;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready: got %b expected 1", bus.in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen = 1'b1;
      step();
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL rst_mid_no_output: got out_valid seen=%b expected 0", seen); end
    drive_pair(14'd7, 3'd0, lat, x, ovf, err);
    n_checks++; if (x !== 16'd35) begin n_errors++; $display("FAIL rst_mid_next: got %0d expected 35", x); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] qs [20];
    logic [2:0]  rs [20];
    logic [15:0] exp_x [20];
    int in_idx, out_idx, cyc, last_cyc;
    for (int i = 0; i < 20; i++) begin
      qs[i]    = 14'(i * 797 + 11);
      rs[i]    = 3'(i % 5);
      exp_x[i] = 16'(5 * (i * 797 + 11) + (i % 5));
    end
    in_idx = 0;
    out_idx = 0;
    last_cyc = -1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (cyc = 0; cyc < 300 && out_idx < 20; cyc++) begin
      bus.in_q = qs[in_idx < 20 ? in_idx : 19];
      bus.in_r = rs[in_idx < 20 ? in_idx : 19];
      if (bus.in_ready && in_idx < 20) in_idx++;
      if (bus.out_valid) begin
        n_checks++;
        if (bus.out_x !== exp_x[out_idx]) begin
          n_errors++;
          $display("FAIL b2b_x[%0d]: got %0d expected %0d", out_idx, bus.out_x, exp_x[out_idx]);
        end
        if (last_cyc >= 0) begin
          n_checks++;
          if (cyc - last_cyc !== 5) begin
            n_errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d expected 5", out_idx, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        out_idx++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (out_idx !== 20) begin n_errors++; $display("FAIL b2b_count: got %0d expected 20", out_idx); end
  endtask

  initial begin
    bus.in_q = 14'd0;
    bus.in_r = 3'd0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_latency();
    test_flags();
    test_backpressure();
    test_reset_midbusy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_const_recon.md
Name: div_const_recon

Overview:
- Inverse of the constant-divisor datapath: rebuilds the dividend X = DIVISOR*Q + R from a quotient/remainder pair.
- Used as an in-system checker and as a golden-side companion to the div_16_5 family.
- Sequential shift-add, one partial product per DIVISOR bit.
- Valid/ready handshake on both sides; one transaction in flight.

Parameters:
- X_WIDTH, 16, dividend width (out_x width).
- Q_WIDTH, 14, quotient width.
- R_WIDTH, 3, remainder width.
- DIVISOR, 5, constant divisor, > 1.
- D_BITS, 3, number of bits in DIVISOR (= clog2(DIVISOR+1)); sets the iteration count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_q  in  Q_WIDTH  quotient.
- in_r  in  R_WIDTH  remainder.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair.
- out_x  out  X_WIDTH  reconstructed dividend, low X_WIDTH bits.
- out_r_err  out  1  remainder was >= DIVISOR.
- out_ovf  out  1  true result exceeded 2^X_WIDTH-1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset is synchronous and active-high; all state is clocked on clk.
- Reset values: state=IDLE; in_ready=1, out_valid=0, out_x=0, out_r_err=0, out_ovf=0; acc, q_reg and cnt are cleared.
- Internal accumulator width is AW = Q_WIDTH + D_BITS + 1. Operands are zero-extended and the arithmetic is unsigned.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge E0: acc <= in_r; q_reg <= in_q; r_err_reg <= (in_r >= DIVISOR); cnt <= 0; go to BUSY.
- State BUSY:
  - in_ready=0.
  - Each edge: if DIVISOR[cnt], acc <= acc + (q_reg << cnt); cnt <= cnt+1.
  - When cnt == D_BITS-1 at the edge, go to DONE.
  - Bits 0..D_BITS-1 are therefore processed at E1..E_D_BITS.
- State DONE:
  - out_valid=1, in_ready=0.
  - out_x = acc[X_WIDTH-1:0]; out_ovf = |acc[AW-1:X_WIDTH]; out_r_err = r_err_reg.
  - All outputs come straight from registers and are driven from DONE entry.
- Latency: out_valid first high in the cycle after edge E_D_BITS, i.e. 3 edges after acceptance for the defaults.
- Output handshake:
  - out_x and the flags stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid <= 0, in_ready <= 1.
  - There is no same-cycle re-accept. Throughput is one pair per D_BITS+2 cycles (5 with defaults).
- in_valid while in_ready=0 is ignored. The pair is not captured, so the producer must hold it.
- out_r_err does not suppress the computation: out_x still equals DIVISOR*Q+R truncated.
- out_ovf and out_r_err may both be set.
- rst asserted in any state, including mid-BUSY: the next edge returns to reset values and the in-flight pair is discarded with no output.
- An out_ready toggle while not in DONE has no effect.
- A DIVISOR bit equal to 0 still costs one BUSY cycle, so latency is fixed and data-independent.

Test Plan:
- Reset, then Q=13107, R=0: in_ready drops the cycle after acceptance; out_valid rises 3 edges after acceptance with out_x=65535, ovf=0, r_err=0.
- Q=13107, R=1: out_x=0, out_ovf=1, out_r_err=0.
- Q=2, R=5: out_x=15, out_r_err=1, out_ovf=0. Then Q=0, R=4: out_x=4, both flags 0.
- Q=100, R=3 with out_ready held low 6 cycles after out_valid:
  - out_x=503 held stable and in_ready=0 throughout.
  - A new in_valid pair (Q=1, R=1) offered in this window is not taken.
  - After the out_ready pulse it is accepted and yields out_x=6.
- Q=500, R=2 accepted, rst asserted for 1 cycle at the second BUSY edge: no out_valid ever appears for that pair; in_ready=1 the cycle after reset; next pair Q=7, R=0 yields out_x=35.
- Back-to-back stream of 20 pairs with out_ready=1 and in_valid always high: one result per 5 cycles, each out_x == 5*Q+R, no drops or duplicates.
